// File: rtl/spi_master_sched.sv
// Mode-0 SPI master with a round-robin scheduler sharing one link between N_REQ requesters.
// Each grant becomes one 32-bit frame: {5'b0, addr, 1'b0, rd, 1'b0} followed by 16 data bits.
module spi_master_sched #(
  parameter int N_REQ   = 2,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic                clk,
  input  logic                rst_btn_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_rd,
  input  logic [8*N_REQ-1:0]  req_addr,
  input  logic [16*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [15:0]         rdata,
  output logic                busy,
  output logic                spi_sclk,
  output logic                spi_mosi,
  output logic                spi_cs_n,
  input  logic                spi_miso
);

  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [4:0]      bidx;
  logic [4:0]      bidx_nx;
  logic [31:0]     tx;
  logic [15:0]     rx;
  logic [IW-1:0]   last;
  logic [IW-1:0]   cur;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            start;
  logic            div_end;
  logic            sel_rd;
  logic [7:0]      sel_addr;
  logic [15:0]     sel_wdata;

  // Rotating search starting just above the last granted requester.
  always_comb begin
    int unsigned j;
    j          = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      j = k + 32'(last);
      if (j >= N_REQ) j = j - N_REQ;
      if (!pick_valid && req[IW'(j)]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(j);
      end
    end
  end

  // Arbitration also runs on the last GAP cycle so a waiting requester loses no extra cycle.
  always_comb begin
    start     = pick_valid && (state == IDLE || (state == GAP && cnt == GAP_LAST));
    div_end   = (cnt == DIV_LAST);
    bidx_nx   = bidx - 5'd1;
    sel_rd    = req_rd[pick_idx];
    sel_addr  = req_addr[8*pick_idx +: 8];
    sel_wdata = req_wdata[16*pick_idx +: 16];
  end

  always_ff @(posedge clk or negedge rst_btn_n) begin
    if (!rst_btn_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bidx     <= 5'd31;
      tx       <= '0;
      rx       <= '0;
      last     <= IW'(N_REQ - 1);
      cur      <= '0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      gnt  <= '0;
      done <= '0;
      if (start) begin
        gnt   <= N_REQ'(1) << pick_idx;
        last  <= pick_idx;
        cur   <= pick_idx;
        tx    <= {5'b0, sel_addr, 1'b0, sel_rd, 1'b0, sel_rd ? 16'h0000 : sel_wdata};
        rx    <= '0;
        busy  <= 1'b1;
        cnt   <= '0;
        bidx  <= 5'd31;
        state <= SETUP;
      end else begin
        case (state)
          IDLE: busy <= 1'b0;
          SETUP: begin
            // The grant cycle keeps CS high; the CLK_DIV setup cycles follow it.
            if (|gnt) begin
              spi_cs_n <= 1'b0;
              spi_mosi <= tx[31];
            end else if (div_end) begin
              cnt   <= '0;
              state <= LOW;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          LOW: begin
            if (div_end) begin
              cnt      <= '0;
              spi_sclk <= 1'b1;
              if (bidx < 5'd16) rx <= {rx[14:0], spi_miso};
              state    <= HIGH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HIGH: begin
            if (div_end) begin
              cnt      <= '0;
              spi_sclk <= 1'b0;
              if (bidx != 5'd0) begin
                bidx     <= bidx_nx;
                spi_mosi <= tx[bidx_nx];
                state    <= LOW;
              end else begin
                state <= HOLD;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (div_end) begin
              cnt      <= '0;
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              done     <= N_REQ'(1) << cur;
              rdata    <= rx;
              state    <= GAP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt   <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_sched.sv
// Bench for spi_master_sched: SPI slave RAM model, round-robin reference and frame-level checks.
module tb_spi_master_sched;

  localparam int N    = 3;
  localparam int CD   = 4;
  localparam int GAPC = 4;

  logic             clk = 1'b0;
  logic             rst_btn_n = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     req_rd = '0;
  logic [8*N-1:0]   req_addr = '0;
  logic [16*N-1:0]  req_wdata = '0;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [15:0]      rdata;
  logic             busy;
  logic             spi_sclk;
  logic             spi_mosi;
  logic             spi_cs_n;
  logic             spi_miso = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_g = N - 1;
  int done_cyc = 0;
  logic [15:0] mem [256];

  spi_master_sched #(.N_REQ(N), .CLK_DIV(CD), .CS_GAP(GAPC)) dut (
    .clk(clk), .rst_btn_n(rst_btn_n), .req(req), .req_rd(req_rd),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  // SPI slave with its own RAM: captures MOSI on rises, drives read data on falls.
  initial begin : slave
    logic [15:0] ram [256];
    logic [31:0] sh;
    logic [15:0] cmd;
    int          cnt;
    logic        p_cs;
    logic        p_sclk;
    for (int a = 0; a < 256; a++) ram[a] = init_val(a);
    ram[8'h12] = 16'hBEEF;
    sh = '0; cmd = '0; cnt = 0; p_cs = 1'b1; p_sclk = 1'b0;
    wait (rst_btn_n === 1'b0);
    #1;
    forever begin
      @(spi_sclk or spi_cs_n);
      if (spi_cs_n) begin
        if (!p_cs && cnt == 32 && !cmd[1]) ram[cmd[10:3]] = sh[15:0];
        spi_miso = 1'b0;
      end else if (p_cs) begin
        cnt = 0;
        sh  = '0;
      end else if (spi_sclk && !p_sclk) begin
        sh = {sh[30:0], spi_mosi};
        cnt++;
      end else if (!spi_sclk && p_sclk && cnt >= 16 && cnt < 32) begin
        if (cnt == 16) cmd = sh[15:0];
        spi_miso = cmd[1] ? ram[cmd[10:3]][31-cnt] : 1'b0;
      end
      p_cs   = spi_cs_n;
      p_sclk = spi_sclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int next_idx(input logic [N-1:0] m, input int l);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (l + k) % N;
      if (m[j]) return j;
    end
    return 0;
  endfunction

  task automatic set_req(input int i, input logic rd, input logic [7:0] a, input logic [15:0] wd);
    req_rd[i]          = rd;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*16 +: 16] = wd;
    req[i]             = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_btn_n = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    rst_btn_n = 1'b1;
    last_g = N - 1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    check("idle_timeout", 32'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  // Follow one granted frame end to end and compare it with the frame the rules predict.
  task automatic run_frame(input int idx, input bit hold, input bit chk_gap);
    logic        rd;
    logic [7:0]  a;
    logic [15:0] wd, exp_rd;
    logic [31:0] exp_word, word;
    int n, rises, cslow, extra, gcyc;
    logic ps;
    rd = req_rd[idx];
    a  = req_addr[idx*8 +: 8];
    wd = req_wdata[idx*16 +: 16];
    exp_word = {5'b0, a, 1'b0, rd, 1'b0, rd ? 16'h0000 : wd};
    exp_rd   = rd ? mem[a] : 16'h0000;
    n = 0;
    while (gnt == '0 && n < 2000) begin @(negedge clk); n++; end
    if (gnt == '0) begin
      check("gnt_timeout", 0, 1);
      return;
    end
    gcyc = cyc;
    check("gnt", 32'(gnt), 32'(1) << idx);
    check("busy_at_gnt", 32'(busy), 1);
    check("cs_at_gnt", 32'(spi_cs_n), 1);
    if (chk_gap) check("cs_gap_ok", 32'((gcyc - done_cyc + 1) >= GAPC + 1), 1);
    last_g = idx;
    if (!hold) req[idx] = 1'b0;
    word = '0; rises = 0; cslow = 0; extra = 0; n = 0;
    ps = spi_sclk;
    while (done == '0 && n < 5000) begin
      @(negedge clk);
      n++;
      if (!spi_cs_n) cslow++;
      if (spi_sclk && !ps) begin
        word = {word[30:0], spi_mosi};
        rises++;
      end
      ps = spi_sclk;
      if (gnt != '0) extra++;
    end
    if (done == '0) begin
      check("done_timeout", 0, 1);
      return;
    end
    done_cyc = cyc;
    check("done", 32'(done), 32'(1) << idx);
    check("cs_at_done", 32'(spi_cs_n), 1);
    check("mosi_at_done", 32'(spi_mosi), 0);
    check("rdata", 32'(rdata), 32'(exp_rd));
    check("sclk_rises", rises, 32);
    check("mosi_word", word, exp_word);
    check("cs_low_cycles", cslow, 66 * CD);
    check("extra_gnt", extra, 0);
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("rdata_held", 32'(rdata), 32'(exp_rd));
    if (!rd) mem[a] = wd;
  endtask

  initial begin
    int e, n, rises;
    logic [N-1:0] mask;
    logic ps;
    for (int a = 0; a < 256; a++) mem[a] = init_val(a);
    mem[8'h12] = 16'hBEEF;

    #2 rst_btn_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 1);
    check("rst_sclk", 32'(spi_sclk), 0);
    check("rst_mosi", 32'(spi_mosi), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_busy", 32'(busy), 0);
    rst_btn_n = 1'b1;
    last_g = N - 1;
    repeat (2) @(negedge clk);

    // Directed write, read-back, boundary address.
    set_req(0, 1'b0, 8'h12, 16'hBEEF);
    run_frame(0, 1'b0, 1'b0);
    wait_idle();
    set_req(1, 1'b1, 8'h12, 16'h1234);
    run_frame(1, 1'b0, 1'b0);
    wait_idle();
    repeat (40) @(negedge clk);
    check("rdata_hold_idle", 32'(rdata), 32'h0000BEEF);
    set_req(2, 1'b1, 8'hFF, 16'(($urandom)));
    run_frame(2, 1'b0, 1'b0);
    wait_idle();

    // Two requesters held high from reset alternate.
    do_reset();
    set_req(0, 1'b0, 8'($urandom), 16'($urandom));
    set_req(1, 1'b1, 8'($urandom), 16'($urandom));
    for (int g = 0; g < 4; g++) begin
      e = next_idx(req, last_g);
      run_frame(e, 1'b1, g > 0);
    end
    req = '0;
    wait_idle();

    // Round-robin with three requesters.
    do_reset();
    set_req(1, 1'b0, 8'($urandom), 16'($urandom));
    run_frame(1, 1'b0, 1'b0);
    wait_idle();
    set_req(0, 1'b1, 8'($urandom), 16'($urandom));
    set_req(2, 1'b0, 8'($urandom), 16'($urandom));
    mask = req;
    while (mask != '0) begin
      e = next_idx(mask, last_g);
      run_frame(e, 1'b0, 1'b1);
      mask[e] = 1'b0;
    end
    wait_idle();

    // Random batches of simultaneous requests.
    for (int b = 0; b < 20; b++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (mask[i]) set_req(i, 1'($urandom), 8'($urandom), 16'($urandom));
      while (mask != '0) begin
        e = next_idx(mask, last_g);
        run_frame(e, 1'b0, 1'b1);
        mask[e] = 1'b0;
      end
      wait_idle();
    end

    // Reset in the middle of a frame, then a fresh frame for the same requester.
    set_req(0, 1'b0, 8'($urandom), 16'($urandom));
    n = 0;
    while (gnt == '0 && n < 2000) begin @(negedge clk); n++; end
    check("mid_gnt", 32'(gnt), 1);
    rises = 0; n = 0;
    ps = spi_sclk;
    while (rises < 21 && n < 5000) begin
      @(negedge clk);
      n++;
      if (spi_sclk && !ps) rises++;
      ps = spi_sclk;
    end
    check("mid_rises", rises, 21);
    rst_btn_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(spi_cs_n), 1);
    check("mid_rst_sclk", 32'(spi_sclk), 0);
    check("mid_rst_busy", 32'(busy), 0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0) n++;
    end
    check("mid_rst_no_done", n, 0);
    rst_btn_n = 1'b1;
    last_g = N - 1;
    run_frame(0, 1'b0, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
